mux8_scan_ctrl: RTL and testbench
=================================

# mux8_scan_ctrl

Sequencer that drives the 3-bit select of `mux8_1` and captures its 1-bit output, converting the eight mux inputs into one parallel byte. On `start` it steps `sel` through 0..7. After each step it waits a programmable settle time, then samples the mux output into bit `sel` of an internal word. The completed word is presented on a valid/ready output. The block sits directly around `mux8_1`: its `sel` feeds the mux select and its `mux_out` input consumes the mux `out`.

## Interface
- `SETTLE_CYCLES`, default 2: cycles waited after each `sel` change before sampling. Legal range 1..255.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a scan; accepted only in IDLE.
- `mux_out` in 1: output of `mux8_1`.
- `ready` in 1: downstream accepts `data`.
- `sel` out 3: select to `mux8_1`.
- `data` out 8: captured word; `data[i]` is `mux_out` sampled while `sel == i`.
- `valid` out 1: `data` is valid.
- `busy` out 1: high in every state except IDLE.
- `parity` out 1: present only with `MUX8_SCAN_PARITY_EN`.

## Operation
- Reset values: `sel=0`, `data=0`, `valid=0`, `busy=0`, `parity=0`. State is IDLE, settle counter 0, capture register 0.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: `sel=0`. When `start=1`, go to SETTLE with counter 0 and capture register cleared.
- SETTLE: counter increments each cycle. When counter equals `SETTLE_CYCLES-1`, go to SAMPLE.
- SAMPLE: lasts one cycle. Capture register bit `[sel]` takes `mux_out`.
  - If `sel != 7`: `sel <= sel+1`, counter cleared, go to SETTLE.
  - If `sel == 7`: `data` takes the full captured word, with the bit sampled in this cycle included. `valid <= 1`, go to DONE.
- DONE: `sel` holds 7, `data` and `valid` held stable. When `valid && ready`, set `valid <= 0` and go to IDLE.
- `start` is ignored in SETTLE, SAMPLE and DONE, including a `start` in the same cycle as the DONE→IDLE handshake.
- `sel` increments only in SAMPLE and never wraps within a scan. It returns to 0 only on entry to IDLE or on reset.
- `data` changes only on the SAMPLE→DONE transition and on reset. It keeps the last word while IDLE.
- Reset mid-operation: the next cycle is IDLE with all outputs at reset values. The partial word is discarded.

## Timing
- Start edge = the clock edge at which `start=1` is sampled in IDLE. The first SETTLE cycle follows that edge.
- Each bit takes `SETTLE_CYCLES+1` cycles. The whole scan takes `8*(SETTLE_CYCLES+1)` cycles.
- `valid` rises `8*(SETTLE_CYCLES+1)+1` cycles after the start edge: 25 cycles with the default.
- `busy` rises 1 cycle after the start edge. It falls 1 cycle after the `valid && ready` edge.
- Minimum start-to-start period: `8*(SETTLE_CYCLES+1)+2` cycles, with `ready` held high.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- `MUX8_SCAN_PARITY_EN` defined:
  - `parity` port exists.
  - `parity` is registered at the same time as `data` and equals `^data` (odd number of ones → 1).
  - `parity` is cleared by reset and held alongside `data`.
- `MUX8_SCAN_PARITY_EN` undefined: no `parity` port and no parity logic.

## Structure
- Package `mux8_scan_pkg`:
  - state enum `{IDLE, SETTLE, SAMPLE, DONE}`;
  - `N_IN = 8`;
  - `SEL_W = 3`;
  - `CNT_W = 8`.
- One sub-module, `mux8_settle_cnt`, owns the settle counter:
  - inputs: `clk`, `rst`, `clear`, `en`;
  - output: `hit` when count equals `SETTLE_CYCLES-1`.
- The FSM, capture register and output registers stay in the top level.

## Test plan
- Static word: behavioural `mux8_1` with `in=8'hA5`, `SETTLE_CYCLES=2`, `ready=1`, pulse `start`.
  - `sel` steps 0..7, holding each value 3 cycles.
  - `valid` high exactly 25 cycles after the start edge with `data=8'hA5`.
  - `busy` low 1 cycle later.
- Backpressure: same scan with `ready=0` for 10 cycles after `valid` rises, then `ready=1`.
  - `valid=1`, `data=8'hA5` and `sel=7` held stable for all 10 cycles.
  - IDLE 1 cycle after `ready` rises.
- Ignored start: pulse `start` again at cycles 5, 12 and during DONE, including the handshake cycle.
  - Exactly one scan occurs and the `sel` sequence is undisturbed.
- Reset mid-scan: assert `rst` at cycle 10 of a scan.
  - Next cycle `sel=0`, `busy=0`, `valid=0`, `data=0`.
  - A following `start` with `in=8'h3C` yields `data=8'h3C`.
- Settle extremes: `SETTLE_CYCLES=1` with `in=8'h81`.
  - `valid` at cycle 17 with `data=8'h81`.
  - Repeat with `SETTLE_CYCLES=255`: `valid` at cycle 2049.
- Parity, with `MUX8_SCAN_PARITY_EN` defined:
  - `in=8'hA5` gives `parity=0`;
  - `in=8'h07` gives `parity=1`;
  - `parity` is 0 after reset.

Source files
------------

// File: rtl/mux8_scan_pkg.sv
// rtl/mux8_scan_pkg.sv - shared widths and state type for the mux8 scan sequencer
package mux8_scan_pkg;
  localparam int N_IN  = 8;
  localparam int SEL_W = 3;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
endpackage

// File: rtl/mux8_scan_if.sv
// rtl/mux8_scan_if.sv - mux select/capture and word valid/ready bundle
// parity member present only when MUX8_SCAN_PARITY_EN is defined
interface mux8_scan_if;
  import mux8_scan_pkg::*;

  logic             start;
  logic             mux_out;
  logic             ready;
  logic [SEL_W-1:0] sel;
  logic [N_IN-1:0]  data;
  logic             valid;
  logic             busy;
`ifdef MUX8_SCAN_PARITY_EN
  logic             parity;
`endif

  modport master (
    output start, mux_out, ready,
`ifdef MUX8_SCAN_PARITY_EN
    input  parity,
`endif
    input  sel, data, valid, busy
  );

  modport slave (
    input  start, mux_out, ready,
`ifdef MUX8_SCAN_PARITY_EN
    output parity,
`endif
    output sel, data, valid, busy
  );
endinterface

// File: rtl/mux8_settle_cnt.sv
// rtl/mux8_settle_cnt.sv - settle-time counter; hit when SETTLE_CYCLES-1 cycles have elapsed
module mux8_settle_cnt
  import mux8_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic hit
);
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign hit = (count == CNT_W'(SETTLE_CYCLES - 1));
endmodule

// File: rtl/mux8_scan_ctrl.sv
// rtl/mux8_scan_ctrl.sv - steps mux8_1 select 0..7 and assembles its output into a byte
// optional parity output enabled by MUX8_SCAN_PARITY_EN
module mux8_scan_ctrl
  import mux8_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  mux8_scan_if.slave  bus
);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_IN - 1);

  state_t           state, state_n;
  logic [SEL_W-1:0] sel_q, sel_n;
  logic [N_IN-1:0]  cap_q, cap_n;
  logic [N_IN-1:0]  data_q, data_n;
  logic             valid_q, valid_n;
  logic             cnt_clear, cnt_en, cnt_hit;
`ifdef MUX8_SCAN_PARITY_EN
  logic             parity_q, parity_n;
`endif

  mux8_settle_cnt #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_settle (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .en    (cnt_en),
    .hit   (cnt_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sel_q   <= '0;
      cap_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
`ifdef MUX8_SCAN_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      sel_q   <= sel_n;
      cap_q   <= cap_n;
      data_q  <= data_n;
      valid_q <= valid_n;
`ifdef MUX8_SCAN_PARITY_EN
      parity_q <= parity_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    sel_n     = sel_q;
    cap_n     = cap_q;
    data_n    = data_q;
    valid_n   = valid_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
`ifdef MUX8_SCAN_PARITY_EN
    parity_n  = parity_q;
`endif
    case (state)
      IDLE: begin
        sel_n     = '0;
        cnt_clear = 1'b1;
        if (bus.start) begin
          cap_n   = '0;
          state_n = SETTLE;
        end
      end
      SETTLE: begin
        cnt_en = 1'b1;
        if (cnt_hit) state_n = SAMPLE;
      end
      SAMPLE: begin
        cnt_clear    = 1'b1;
        cap_n[sel_q] = bus.mux_out;
        if (sel_q != SEL_LAST) begin
          sel_n   = sel_q + SEL_W'(1);
          state_n = SETTLE;
        end else begin
          // publish the word including the bit captured this cycle
          data_n  = cap_n;
          valid_n = 1'b1;
`ifdef MUX8_SCAN_PARITY_EN
          parity_n = ^cap_n;
`endif
          state_n = DONE;
        end
      end
      DONE: begin
        if (valid_q && bus.ready) begin
          valid_n = 1'b0;
          sel_n   = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.sel   = sel_q;
  assign bus.data  = data_q;
  assign bus.valid = valid_q;
  assign bus.busy  = (state != IDLE);
`ifdef MUX8_SCAN_PARITY_EN
  assign bus.parity = parity_q;
`endif
endmodule

// File: tb/tb_mux8_scan_ctrl.sv
// tb/tb_mux8_scan_ctrl.sv - self-checking bench for mux8_scan_ctrl with a behavioural mux8_1
// parity checks compiled in when MUX8_SCAN_PARITY_EN is defined
module tb_mux8_scan_ctrl;
  localparam int S    = 2;
  localparam int SCAN = 8 * (S + 1);
  localparam int MAXC = 400;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] in_word;
  logic [7:0] in_x;

  mux8_scan_if m();
  mux8_scan_if m1();
  mux8_scan_if m255();

  assign m.mux_out    = in_word[m.sel];
  assign m1.mux_out   = in_x[m1.sel];
  assign m255.mux_out = in_x[m255.sel];

  always #5 clk = ~clk;

  mux8_scan_ctrl #(.SETTLE_CYCLES(S))   dut     (.clk(clk), .rst(rst), .bus(m.slave));
  mux8_scan_ctrl #(.SETTLE_CYCLES(1))   dut_s1  (.clk(clk), .rst(rst), .bus(m1.slave));
  mux8_scan_ctrl #(.SETTLE_CYCLES(255)) dut_s255(.clk(clk), .rst(rst), .bus(m255.slave));

  logic [2:0] sel_tr   [MAXC];
  logic [7:0] data_tr  [MAXC];
  logic       valid_tr [MAXC];
  logic       busy_tr  [MAXC];
  int         vr, bf, idle_bad;
  logic [7:0] data_at_valid;
  logic       par_at_valid;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // cycle n is the interval following the n-th edge counted from the start edge (n=1 right after it)
  task automatic run_scan(input logic [7:0] word, input int rdly, input bit spam, input int tail);
    in_word  = word;
    m.ready  = (rdly == 0);
    m.start  = 1'b1;
    vr       = 0;
    bf       = 0;
    idle_bad = 0;
    par_at_valid = 1'b0;
    tick();
    m.start = 1'b0;
    for (int n = 1; n < MAXC; n++) begin
      sel_tr[n]   = m.sel;
      data_tr[n]  = m.data;
      valid_tr[n] = m.valid;
      busy_tr[n]  = m.busy;
      if (vr == 0 && m.valid) begin
        vr = n;
        data_at_valid = m.data;
`ifdef MUX8_SCAN_PARITY_EN
        par_at_valid = m.parity;
`endif
      end
      if (vr != 0 && bf == 0 && !m.busy) bf = n;
      if (bf != 0) break;
      if (vr != 0 && n - vr >= rdly) m.ready = 1'b1;
      m.start = spam && (n == 5 || n == 12 || m.valid);
      tick();
    end
    m.start = 1'b0;
    m.ready = 1'b1;
    for (int t = 0; t < tail; t++) begin
      tick();
      if (m.busy) idle_bad++;
    end
  endtask

  function automatic int trace_errs(input logic [7:0] word);
    int e = 0;
    logic [2:0] es;
    for (int n = 1; n <= bf; n++) begin
      if (n <= SCAN) es = 3'((n - 1) / (S + 1));
      else if (n < bf) es = 3'd7;
      else es = 3'd0;
      if (sel_tr[n] !== es) e++;
      if (valid_tr[n] !== (n > SCAN && n < bf)) e++;
      if (busy_tr[n] !== (n < bf)) e++;
      if (n > SCAN && data_tr[n] !== word) e++;
    end
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (m.sel !== 3'd0)   begin errors++; $display("FAIL reset_sel got %0d want 0", m.sel); end
    checks++; if (m.data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", m.data); end
    checks++; if (m.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", m.valid); end
    checks++; if (m.busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b want 0", m.busy); end
`ifdef MUX8_SCAN_PARITY_EN
    checks++; if (m.parity !== 1'b0) begin errors++; $display("FAIL reset_parity got %b want 0", m.parity); end
`endif
  endtask

  task automatic test_static_word();
    run_scan(8'hA5, 0, 1'b0, 2);
    checks++; if (vr !== SCAN + 1) begin errors++; $display("FAIL static_valid_cycle got %0d want %0d", vr, SCAN + 1); end
    checks++; if (data_at_valid !== 8'hA5) begin errors++; $display("FAIL static_data got %h want a5", data_at_valid); end
    checks++; if (bf !== SCAN + 2) begin errors++; $display("FAIL static_busy_fall got %0d want %0d", bf, SCAN + 2); end
    checks++; if (trace_errs(8'hA5) !== 0) begin errors++; $display("FAIL static_trace got %0d bad cycles want 0", trace_errs(8'hA5)); end
    checks++; if (idle_bad !== 0) begin errors++; $display("FAIL static_idle got %0d busy cycles want 0", idle_bad); end
`ifdef MUX8_SCAN_PARITY_EN
    checks++; if (par_at_valid !== 1'b0) begin errors++; $display("FAIL parity_a5 got %b want 0", par_at_valid); end
`endif
  endtask

  task automatic test_backpressure();
    run_scan(8'hA5, 10, 1'b0, 1);
    checks++; if (vr !== SCAN + 1) begin errors++; $display("FAIL bp_valid_cycle got %0d want %0d", vr, SCAN + 1); end
    checks++; if (bf !== SCAN + 1 + 10 + 1) begin errors++; $display("FAIL bp_busy_fall got %0d want %0d", bf, SCAN + 12); end
    checks++; if (trace_errs(8'hA5) !== 0) begin errors++; $display("FAIL bp_hold_trace got %0d bad cycles want 0", trace_errs(8'hA5)); end
  endtask

  task automatic test_ignored_start();
    run_scan(8'h5E, 2, 1'b1, 4);
    checks++; if (vr !== SCAN + 1) begin errors++; $display("FAIL ign_valid_cycle got %0d want %0d", vr, SCAN + 1); end
    checks++; if (trace_errs(8'h5E) !== 0) begin errors++; $display("FAIL ign_trace got %0d bad cycles want 0", trace_errs(8'h5E)); end
    checks++; if (idle_bad !== 0) begin errors++; $display("FAIL ign_extra_scan got %0d busy cycles want 0", idle_bad); end
  endtask

  task automatic test_back_to_back();
    run_scan(8'hC3, 0, 1'b0, 0);
    checks++; if (data_at_valid !== 8'hC3) begin errors++; $display("FAIL b2b_first_data got %h want c3", data_at_valid); end
    run_scan(8'h19, 0, 1'b0, 1);
    checks++; if (vr !== SCAN + 1) begin errors++; $display("FAIL b2b_valid_cycle got %0d want %0d", vr, SCAN + 1); end
    checks++; if (data_at_valid !== 8'h19) begin errors++; $display("FAIL b2b_second_data got %h want 19", data_at_valid); end
  endtask

  task automatic test_reset_mid_scan();
    in_word = 8'hE7;
    m.start = 1'b1;
    tick();
    m.start = 1'b0;
    for (int n = 1; n < 10; n++) tick();
    checks++; if (m.sel !== 3'd3) begin errors++; $display("FAIL mid_sel_before got %0d want 3", m.sel); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (m.sel !== 3'd0)   begin errors++; $display("FAIL mid_sel got %0d want 0", m.sel); end
    checks++; if (m.busy !== 1'b0)  begin errors++; $display("FAIL mid_busy got %b want 0", m.busy); end
    checks++; if (m.valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", m.valid); end
    checks++; if (m.data !== 8'h00) begin errors++; $display("FAIL mid_data got %h want 00", m.data); end
`ifdef MUX8_SCAN_PARITY_EN
    checks++; if (m.parity !== 1'b0) begin errors++; $display("FAIL mid_parity got %b want 0", m.parity); end
`endif
    run_scan(8'h3C, 0, 1'b0, 1);
    checks++; if (data_at_valid !== 8'h3C) begin errors++; $display("FAIL mid_rescan_data got %h want 3c", data_at_valid); end
  endtask

  task automatic test_random();
    logic [7:0] w;
    int d;
    bit sp;
    for (int i = 0; i < 6; i++) begin
      w  = 8'($urandom);
      d  = int'($urandom_range(0, 6));
      sp = 1'($urandom_range(0, 1));
      run_scan(w, d, sp, 2);
      checks++; if (data_at_valid !== w) begin errors++; $display("FAIL rnd_data[%0d] got %h want %h", i, data_at_valid, w); end
      checks++; if (vr !== SCAN + 1) begin errors++; $display("FAIL rnd_valid_cycle[%0d] got %0d want %0d", i, vr, SCAN + 1); end
      checks++; if (bf !== SCAN + 1 + d + 1) begin errors++; $display("FAIL rnd_busy_fall[%0d] got %0d want %0d", i, bf, SCAN + d + 2); end
      checks++; if (trace_errs(w) !== 0) begin errors++; $display("FAIL rnd_trace[%0d] got %0d bad cycles want 0", i, trace_errs(w)); end
      checks++; if (idle_bad !== 0) begin errors++; $display("FAIL rnd_idle[%0d] got %0d busy cycles want 0", i, idle_bad); end
`ifdef MUX8_SCAN_PARITY_EN
      checks++; if (par_at_valid !== ^w) begin errors++; $display("FAIL rnd_parity[%0d] got %b want %b", i, par_at_valid, ^w); end
`endif
    end
  endtask

  task automatic test_settle_extremes();
    int v1 = 0;
    int v255 = 0;
    logic [7:0] d1, d255;
    d1 = 8'h00;
    d255 = 8'h00;
    in_x = 8'h81;
    m1.start = 1'b1;
    m255.start = 1'b1;
    tick();
    m1.start = 1'b0;
    m255.start = 1'b0;
    for (int n = 1; n < 2200; n++) begin
      if (v1 == 0 && m1.valid) begin v1 = n; d1 = m1.data; end
      if (v255 == 0 && m255.valid) begin v255 = n; d255 = m255.data; end
      if (v1 != 0 && v255 != 0) break;
      tick();
    end
    checks++; if (v1 !== 17) begin errors++; $display("FAIL s1_valid_cycle got %0d want 17", v1); end
    checks++; if (d1 !== 8'h81) begin errors++; $display("FAIL s1_data got %h want 81", d1); end
    checks++; if (v255 !== 2049) begin errors++; $display("FAIL s255_valid_cycle got %0d want 2049", v255); end
    checks++; if (d255 !== 8'h81) begin errors++; $display("FAIL s255_data got %h want 81", d255); end
  endtask

`ifdef MUX8_SCAN_PARITY_EN
  task automatic test_parity();
    run_scan(8'h07, 0, 1'b0, 1);
    checks++; if (par_at_valid !== 1'b1) begin errors++; $display("FAIL parity_07 got %b want 1", par_at_valid); end
    checks++; if (data_at_valid !== 8'h07) begin errors++; $display("FAIL parity_07_data got %h want 07", data_at_valid); end
  endtask
`endif

  initial begin
    rst        = 1'b1;
    in_word    = 8'h00;
    in_x       = 8'h00;
    m.start    = 1'b0;
    m.ready    = 1'b1;
    m1.start   = 1'b0;
    m1.ready   = 1'b1;
    m255.start = 1'b0;
    m255.ready = 1'b1;
    test_reset();
    test_static_word();
    test_backpressure();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_scan();
    test_random();
`ifdef MUX8_SCAN_PARITY_EN
    test_parity();
`endif
    test_settle_extremes();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
